// File: rtl/clkdiv_ctrl_pkg.sv
// clkdiv_ctrl_pkg: shared state encoding and default ratio width for the clock divider
package clkdiv_ctrl_pkg;
    localparam int RW_DEF = 4;
    typedef enum logic [1:0] {STOP, RUN, PEND} state_e;
endpackage

// File: rtl/clkdiv_ctrl_core.sv
// clkdiv_core: phase counter, duty-cycle flops and glitch-free output mux of the divider
module clkdiv_core
    import clkdiv_ctrl_pkg::*;
#(
    parameter int RW = RW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [RW-1:0] ratio_i,
    input  logic [RW-1:0] nxt_ratio_i,
    input  logic          run_i,
    output logic          clk_out_o,
    output logic          period_end_o,
    output logic          period_start_o
);
    localparam logic [RW-1:0] ONE = RW'(1);
    logic [RW-1:0] posc_q, posc_d;
    logic [RW:0]   half;
    logic          p_q, p_d, n_q, en_q, running;
    assign running        = ratio_i != '0;
    assign half           = ({1'b0, ratio_i} + 1'b1) >> 1;
    assign period_end_o   = running && (posc_q == ratio_i - 1'b1);
    assign period_start_o = running && (posc_q == '0);
    assign clk_out_o      = (ratio_i == ONE) ? (clk & en_q) : (ratio_i[0] ? (p_q & n_q) : p_q);
    // next phase count and high-phase flag; a fresh period always opens high
    always_comb begin
        posc_d = (!run_i || !running || period_end_o) ? '0 : posc_q + 1'b1;
        p_d    = run_i && (posc_d == '0 || {1'b0, posc_d} < half);
    end
    // posedge phase counter and high-phase register
    always_ff @(posedge clk) begin
        if (rst) begin
            posc_q <= '0;
            p_q    <= 1'b0;
        end else begin
            posc_q <= posc_d;
            p_q    <= p_d;
        end
    end
    // negedge half-cycle shadow of p (masked for N=1) and N=1 gate enable looked up one period ahead
    always_ff @(negedge clk) begin
        if (rst) begin
            n_q  <= 1'b0;
            en_q <= 1'b0;
        end else begin
            n_q  <= p_q && (ratio_i != ONE);
            en_q <= nxt_ratio_i == ONE;
        end
    end
endmodule

// File: rtl/clkdiv_ctrl.sv
// clkdiv_ctrl: ratio-change handshake and STOP/RUN/PEND sequencing around the divider core
module clkdiv_ctrl
    import clkdiv_ctrl_pkg::*;
#(
    parameter int RW = RW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    input  logic [RW-1:0] req_ratio,
    output logic          req_ready,
    output logic          clk_out,
    output logic [RW-1:0] active_ratio,
    output logic          period_start
);
    state_e        state_q, state_d;
    logic [RW-1:0] active_q, active_d, pend_q, pend_d, nxt_ratio;
    logic          acc, period_end;
    assign active_ratio = active_q;
    assign nxt_ratio    = (state_q == PEND) ? pend_q : active_q;
    // next-state, ratio loading and handshake; new ratios only take effect at a period boundary
    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        pend_d    = pend_q;
        req_ready = state_q != PEND;
        acc       = req_valid && req_ready;
        if (state_q == STOP) begin
            if (acc && req_ratio != '0) begin
                state_d  = RUN;
                active_d = req_ratio;
            end
        end else if (state_q == RUN) begin
            if (acc) begin
                state_d = PEND;
                pend_d  = req_ratio;
            end
        end else if (period_end) begin
            active_d = pend_q;
            pend_d   = '0;
            state_d  = (pend_q != '0) ? RUN : STOP;
        end
    end
    // state and ratio registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= STOP;
            active_q <= '0;
            pend_q   <= '0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            pend_q   <= pend_d;
        end
    end
    clkdiv_core #(.RW(RW)) u_core (
        .clk           (clk),
        .rst           (rst),
        .ratio_i       (active_q),
        .nxt_ratio_i   (nxt_ratio),
        .run_i         (state_d != STOP),
        .clk_out_o     (clk_out),
        .period_end_o  (period_end),
        .period_start_o(period_start)
    );
endmodule

// File: tb/tb_clkdiv_ctrl.sv
// tb_clkdiv_ctrl: directed scoreboard bench for the clock divider controller
module tb_clkdiv_ctrl;
    logic       clk = 1'b0, rst = 1'b1, req_valid = 1'b0;
    logic [3:0] req_ratio = '0;
    logic       req_ready, clk_out, period_start;
    logic [3:0] active_ratio;
    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];
    int   n_cmp = 0, n_err = 0;

    clkdiv_ctrl #(.RW(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ratio   (req_ratio),
        .req_ready   (req_ready),
        .clk_out     (clk_out),
        .active_ratio(active_ratio),
        .period_start(period_start)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic cmp(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $error("FAIL sb_empty observed=%0d required=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_err++;
                $error("FAIL %s observed=%0d required=%0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] exp, input logic [31:0] obs);
        push(tag, exp);
        cmp(obs);
    endtask

    task automatic wait_lvl(input logic lvl, output time t);
        bit done = 1'b0;
        t = $time;
        for (int i = 0; i < 200 && !done; i++) begin
            if (clk_out === lvl) done = 1'b1;
            else begin
                @(clk or clk_out);
                #1;
                t = $time - 1;
            end
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $error("FAIL clk_out_timeout observed=stuck required=%0b", lvl);
        end
    endtask

    // high time and period of clk_out in half source periods (5 time units)
    task automatic meas();
        time tr, tf, tr2;
        wait_lvl(1'b0, tr);
        wait_lvl(1'b1, tr);
        wait_lvl(1'b0, tf);
        wait_lvl(1'b1, tr2);
        cmp(32'((tf - tr) / 5));
        cmp(32'((tr2 - tr) / 5));
    endtask

    task automatic wait_active(input logic [3:0] tgt, input int budget);
        for (int i = 0; i < budget && active_ratio !== tgt; i++) tick();
        cmp(32'(active_ratio));
    endtask

    task automatic count_ps(input int n);
        int c = 0;
        repeat (n) begin
            tick();
            if (period_start === 1'b1) c++;
        end
        cmp(c);
    endtask

    task automatic count_act(input int n, input logic [3:0] v);
        int c = 0;
        repeat (n) begin
            tick();
            if (active_ratio === v) c++;
        end
        cmp(c);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ready", 1, req_ready);
        chk("rst_active", 0, active_ratio);
        chk("rst_pstart", 0, period_start);
        chk("rst_clk_out", 0, clk_out);

        push("n5_active", 5);
        push("n5_pstart", 1);
        push("n5_hi", 5);
        push("n5_per", 10);
        push("n5_pcount", 2);
        req_valid = 1'b1;
        req_ratio = 4'd5;
        tick();
        req_valid = 1'b0;
        cmp(32'(active_ratio));
        cmp(32'(period_start));
        meas();
        count_ps(10);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_valid = 1'b1;
        req_ratio = 4'd4;
        tick();
        req_valid = 1'b0;
        tick();
        req_valid = 1'b1;
        req_ratio = 4'd3;
        tick();
        req_valid = 1'b0;
        chk("n4_acc_ready", 0, req_ready);
        tick();
        chk("n4_last_ready", 0, req_ready);
        chk("n4_last_active", 4, active_ratio);
        tick();
        chk("n3_active", 3, active_ratio);
        chk("n3_pstart", 1, period_start);
        chk("n3_ready", 1, req_ready);
        push("n3_hi", 3);
        push("n3_per", 6);
        meas();

        push("n7_active", 7);
        req_valid = 1'b1;
        req_ratio = 4'd7;
        tick();
        req_valid = 1'b0;
        wait_active(4'd7, 10);
        req_valid = 1'b1;
        req_ratio = 4'd0;
        tick();
        req_valid = 1'b0;
        repeat (5) tick();
        chk("n7_tail_active", 7, active_ratio);
        chk("n7_tail_ready", 0, req_ready);
        tick();
        chk("stop_active", 0, active_ratio);
        chk("stop_ready", 1, req_ready);
        chk("stop_clk_out", 0, clk_out);
        chk("stop_pstart", 0, period_start);
        repeat (3) tick();
        #2;
        chk("stop_clk_out_late", 0, clk_out);

        req_valid = 1'b1;
        req_ratio = 4'd2;
        tick();
        req_ratio = 4'd6;
        tick();
        req_ratio = 4'd9;
        chk("b2b_pend_ready", 0, req_ready);
        chk("b2b_pend_active", 2, active_ratio);
        tick();
        chk("b2b_n6_active", 6, active_ratio);
        chk("b2b_n6_ready", 1, req_ready);
        chk("b2b_n6_pstart", 1, period_start);
        tick();
        req_valid = 1'b0;
        chk("b2b_n9_acc_ready", 0, req_ready);
        chk("b2b_n9_acc_active", 6, active_ratio);
        repeat (4) tick();
        chk("b2b_n6_tail_active", 6, active_ratio);
        tick();
        chk("b2b_n9_active", 9, active_ratio);
        chk("b2b_n9_pstart", 1, period_start);
        push("n9_hi", 9);
        push("n9_per", 18);
        meas();

        push("n5b_active", 5);
        req_valid = 1'b1;
        req_ratio = 4'd5;
        tick();
        req_valid = 1'b0;
        wait_active(4'd5, 20);
        req_valid = 1'b1;
        req_ratio = 4'd2;
        tick();
        req_valid = 1'b0;
        chk("pend2_ready", 0, req_ready);
        rst = 1'b1;
        req_valid = 1'b1;
        req_ratio = 4'd3;
        tick();
        chk("midrst_active", 0, active_ratio);
        chk("midrst_ready", 1, req_ready);
        chk("midrst_pstart", 0, period_start);
        chk("midrst_clk_out", 0, clk_out);
        tick();
        rst = 1'b0;
        req_valid = 1'b0;
        push("no_pending2", 0);
        count_act(12, 4'd2);
        chk("post_rst_active", 0, active_ratio);

        push("n1_active", 1);
        push("n1_hi", 1);
        push("n1_per", 2);
        push("n1_pcount", 6);
        req_valid = 1'b1;
        req_ratio = 4'd1;
        tick();
        req_valid = 1'b0;
        cmp(32'(active_ratio));
        meas();
        count_ps(6);

        push("n15_active", 15);
        push("n15_hi", 15);
        push("n15_per", 30);
        push("n15_pcount", 2);
        req_valid = 1'b1;
        req_ratio = 4'd15;
        tick();
        req_valid = 1'b0;
        wait_active(4'd15, 5);
        meas();
        count_ps(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/clkdiv_ctrl.md
CLKDIV_CTRL -- requirements
Module: clkdiv_ctrl

Interface
REQ-001 SHALL have parameter: RW, 4, width of divide-ratio field (ratios 1..2^RW-1).
REQ-002 SHALL have port: clk  input  1  source clock; all state on posedge except the negedge phase flop.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: req_valid  input  1  ratio-change request valid.
REQ-005 SHALL have port: req_ratio  input  RW  requested divide ratio N; 0 = stop output.
REQ-006 SHALL have port: req_ready  output  1  controller can accept a request.
REQ-007 SHALL have port: clk_out  output  1  divided clock, 50% duty for all N>=2.
REQ-008 SHALL have port: active_ratio  output  RW  ratio currently driving clk_out (0 when stopped).
REQ-009 SHALL have port: period_start  output  1  one-cycle pulse on each posedge where the phase counter is 0 while running.

Function
REQ-010 SHALL implement states STOP, RUN, PEND.
REQ-011 SHALL assert req_ready in STOP and RUN, deassert in PEND; a request is accepted on posedge with req_valid & req_ready.
REQ-012 STOP + accepted N>=1: SHALL load N, enter RUN, posc=0 on the next posedge; N=0 accepted and ignored (stays STOP).
REQ-013 RUN + accepted request: SHALL latch pending ratio, enter PEND; active_ratio unchanged.
REQ-014 PEND: on the posedge where posc==active_ratio-1 (period end) SHALL load pending ratio, posc=0, go to RUN (or STOP if pending==0); no truncated or stretched high phase.
REQ-015 posc SHALL count 0..N-1 on posedge, wrapping to 0; width RW.
REQ-016 p (posedge reg) SHALL be high for posc < ceil(N/2); n SHALL be p re-registered on negedge.
REQ-017 Even N: clk_out = p; odd N>=3: clk_out = p & n (high N/2 source periods); N=1: clk_out = p with p held high is forbidden -- N=1 SHALL output clk gated by a negedge-registered enable (glitch-free).
REQ-018 STOP: clk_out, p, n SHALL be 0; active_ratio=0; period_start=0.
REQ-019 req_valid held across PEND SHALL not be consumed until req_ready returns; the request present on the RUN-entry cycle is accepted normally.
REQ-020 Same ratio requested while RUN SHALL still pass through PEND (restart phase at boundary, no glitch).

Reset
REQ-021 On rst posedge: state=STOP, posc=0, p=0, pending=0, active_ratio=0, period_start=0, req_ready=1.
REQ-022 Negedge flops SHALL clear on the negedge where rst is sampled high; clk_out SHALL be 0 no later than one full clk period after rst assertion.
REQ-023 rst mid-RUN/PEND SHALL discard pending ratio; no request accepted while rst=1.

Structure
REQ-024 Shared package SHALL hold state enum (STOP/RUN/PEND) and default RW.
REQ-025 Divider datapath (posc, p, n, output mux) SHALL be sub-module clkdiv_core, with ratio and run inputs and period_end/period_start outputs; clkdiv_ctrl holds FSM and handshake.

Verification
REQ-026 Reset then request N=5 -> clk_out period 5 clk, high exactly 2.5 clk; active_ratio=5 one posedge after accept.
REQ-027 RUN N=4, request N=3 mid-period -> req_ready low until period end; first N=3 period starts posc=0 immediately after the last full N=4 period.
REQ-028 RUN N=7, request 0 -> completes current 7-cycle period, clk_out low after, active_ratio=0, state STOP.
REQ-029 Back-to-back valid with ratios 6 then 9 -> 6 accepted, 9 held during PEND, accepted next RUN cycle, applied at next 6-period boundary.
REQ-030 rst asserted in PEND (N=5 -> pending 2) -> all outputs reset values; pending 2 never appears on active_ratio.
REQ-031 N=1 and N=15 sweep -> clk_out period 1 and 15 clk, no pulse narrower than half source period, period_start once per period.
